mem_ctrl: RTL and testbench

//  Sole owner of the byte-wide external memory/IO bus (mem_a/mem_din/mem_dout/mem_wr).

---
 rtl/riscv_defs.sv | 28 ++
 rtl/mem_byte_seq.sv | 128 ++++++++++++
 rtl/mem_ctrl.sv | 104 ++++++++++
 tb/tb_mem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// Shared definitions for the memory controller: LSB size encodings, controller
// FSM states, arbitration grant type and the IO-space address decode value.
package riscv_defs;

  localparam logic [1:0] IO_SPACE_SEL = 2'b11;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic { GRANT_IC = 1'b0, GRANT_LSB = 1'b1 } grant_e;

  // Index of the final byte of an LSB access; the illegal size 3 behaves as a word.
  function automatic logic [1:0] size_last_idx(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 2'd0;
      SIZE_HALF: return 2'd1;
      SIZE_WORD: return 2'd3;
      default:   return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer for the external bus: issues consecutive byte addresses,
// shifts store data out and assembles read bytes (little-endian) into a word.
module mem_byte_seq
  import riscv_defs::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_SEL     = IO_SPACE_SEL
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  io_buffer_full,
  input  logic                  start,
  input  logic                  start_we,
  input  logic [1:0]            start_last,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [31:0]           start_wdata,
  input  logic                  active,
  input  logic [7:0]            mem_din,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr,
  output logic                  finish,
  output logic [31:0]           word_next
);

  logic                  we;
  logic                  wr_q;
  logic                  live;
  logic                  pend;
  logic                  is_io;
  logic [1:0]            last_idx;
  logic [1:0]            iss;
  logic [1:0]            next_iss;
  logic [1:0]            cap;
  logic [ADDR_WIDTH-1:0] base;
  logic [23:0]           wbuf;
  logic [31:0]           rbuf;
  logic                  io_stall;
  logic                  step;

  assign io_stall = is_io && io_buffer_full;
  assign step     = active && rdy_in;
  assign next_iss = iss + 2'd1;

  // Strobe is gated combinationally so a paused or stalled cycle never writes.
  assign mem_wr = wr_q && rdy_in && !io_stall;

  assign finish = step && (we ? (wr_q && !io_stall && iss == last_idx)
                              : (pend && cap == last_idx));

  // NOTE: the full default assignment first keeps this block free of latches.
  always_comb begin
    word_next = rbuf;
    word_next[{cap, 3'b000} +: 8] = mem_din;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      we       <= 1'b0;
      wr_q     <= 1'b0;
      live     <= 1'b0;
      pend     <= 1'b0;
      is_io    <= 1'b0;
      last_idx <= '0;
      iss      <= '0;
      cap      <= '0;
      base     <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      wbuf     <= '0;
      rbuf     <= '0;
    end else if (start) begin
      base     <= start_addr;
      mem_a    <= start_addr;
      we       <= start_we;
      wr_q     <= start_we;
      last_idx <= start_last;
      is_io    <= (start_addr[17:16] == IO_SEL);
      iss      <= '0;
      cap      <= '0;
      live     <= 1'b1;
      pend     <= 1'b0;
      rbuf     <= '0;
      if (start_we) begin
        mem_dout <= start_wdata[7:0];
        wbuf     <= start_wdata[31:8];
      end
    end else if (active && !rdy_in) begin
      // A paused read loses the byte in flight, so re-issue from the next uncaptured byte.
      if (!we) begin
        iss   <= cap;
        mem_a <= base + ADDR_WIDTH'(cap);
        live  <= 1'b1;
        pend  <= 1'b0;
      end
    end else if (step) begin
      if (we) begin
        if (!io_stall) begin
          if (iss == last_idx) begin
            wr_q <= 1'b0;
          end else begin
            iss      <= next_iss;
            mem_a    <= base + ADDR_WIDTH'(next_iss);
            mem_dout <= wbuf[7:0];
            wbuf     <= wbuf >> 8;
          end
        end
      end else begin
        if (pend) begin
          rbuf[{cap, 3'b000} +: 8] <= mem_din;
          cap <= cap + 2'd1;
        end
        pend <= live;
        if (live) begin
          if (iss == last_idx) begin
            live <= 1'b0;
          end else begin
            iss   <= next_iss;
            mem_a <= base + ADDR_WIDTH'(next_iss);
          end
        end
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates IC fetches and LSB accesses for the byte-wide
// external bus and returns one-cycle ready pulses with the assembled data.
module mem_ctrl
  import riscv_defs::*;
#(
  parameter int         ADDR_WIDTH     = 32,
  parameter int         IC_FETCH_BYTES = 4,
  parameter logic [1:0] IO_SEL         = IO_SPACE_SEL
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  input  logic                  ic_abort,
  output logic                  ic_ready,
  output logic [31:0]           ic_data,
  input  logic                  lsb_req,
  input  logic                  lsb_we,
  input  logic [1:0]            lsb_size,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [31:0]           lsb_wdata,
  output logic                  lsb_ready,
  output logic [31:0]           lsb_rdata
);

  logic [1:0]  state;
  grant_e      last_grant;
  logic        pick_lsb;
  logic        accept;
  logic        active;
  logic        finish;
  logic [31:0] word_next;

  // With both requesting, the side not served last wins.
  assign pick_lsb = lsb_req && (!ic_req || last_grant == GRANT_IC);
  assign accept   = rdy_in && (state == ST_IDLE) && (ic_req || lsb_req);
  assign active   = (state == ST_READ) || (state == ST_WRITE);

  mem_byte_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .IO_SEL     (IO_SEL)
  ) u_seq (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .io_buffer_full (io_buffer_full),
    .start          (accept),
    .start_we       (pick_lsb && lsb_we),
    .start_last     (pick_lsb ? size_last_idx(lsb_size) : 2'(IC_FETCH_BYTES - 1)),
    .start_addr     (pick_lsb ? lsb_addr : ic_addr),
    .start_wdata    (lsb_wdata),
    .active         (active),
    .mem_din        (mem_din),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .finish         (finish),
    .word_next      (word_next)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_IC;
      ic_ready   <= 1'b0;
      lsb_ready  <= 1'b0;
      ic_data    <= '0;
      lsb_rdata  <= '0;
    end else if (rdy_in) begin
      ic_ready  <= 1'b0;
      lsb_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ic_req || lsb_req) begin
            last_grant <= pick_lsb ? GRANT_LSB : GRANT_IC;
            state      <= (pick_lsb && lsb_we) ? ST_WRITE : ST_READ;
          end
        end
        ST_READ, ST_WRITE: begin
          if (state == ST_READ && last_grant == GRANT_IC && ic_abort) begin
            state <= ST_IDLE;
          end else if (finish) begin
            state <= ST_DONE;
            if (last_grant == GRANT_IC) begin
              ic_ready <= 1'b1;
              ic_data  <= word_next;
            end else begin
              lsb_ready <= 1'b1;
              if (state == ST_READ) lsb_rdata <= word_next;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed transactions push expected responses
// and bus writes into queues; monitors pop and compare as the DUT presents them.
module tb_mem_ctrl;

  typedef struct {
    bit          lsb;
    logic [31:0] data;
    int          due;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_abort;
  logic        ic_ready;
  logic [31:0] ic_data;
  logic        lsb_req;
  logic        lsb_we;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_ready;
  logic [31:0] lsb_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  resp_t       exp_q[$];
  wr_t         wr_exp[$];
  logic [7:0]  mem [logic [31:0]];

  mem_ctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .ic_req         (ic_req),
    .ic_addr        (ic_addr),
    .ic_abort       (ic_abort),
    .ic_ready       (ic_ready),
    .ic_data        (ic_data),
    .lsb_req        (lsb_req),
    .lsb_we         (lsb_we),
    .lsb_size       (lsb_size),
    .lsb_addr       (lsb_addr),
    .lsb_wdata      (lsb_wdata),
    .lsb_ready      (lsb_ready),
    .lsb_rdata      (lsb_rdata)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Byte memory: read data appears the cycle after its address.
  always @(posedge clk_in) begin
    mem_din <= mem.exists(mem_a) ? mem[mem_a] : 8'h00;
    if (mem_wr) mem[mem_a] = mem_dout;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // Response monitor.
  always @(negedge clk_in) begin
    if (!rst_in && (ic_ready || lsb_ready)) begin
      if (ic_ready && lsb_ready) begin
        check("both_ready", 1'b1, 1'b0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_ready_lsb", lsb_ready, 1'b0);
        check("unexpected_ready_ic", ic_ready, 1'b0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("grant_is_lsb", lsb_ready, e.lsb);
        check("resp_data", e.lsb ? lsb_rdata : ic_data, e.data);
        if (e.due >= 0) check("resp_latency", cyc, e.due);
      end
    end
  end

  // Bus write monitor.
  always @(negedge clk_in) begin
    if (!rst_in && mem_wr) begin
      if (wr_exp.size() == 0) begin
        check("unexpected_write", mem_wr, 1'b0);
      end else begin
        wr_t w;
        w = wr_exp.pop_front();
        check("write_addr", mem_a, w.addr);
        check("write_data", mem_dout, w.data);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  task automatic wait_ready(input bit lsb, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      tick();
      seen = lsb ? lsb_ready : ic_ready;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no ready pulse within 80 cycles, required one", name);
    end
  endtask

  task automatic push_resp(input bit lsb, input logic [31:0] data, input int due);
    resp_t e;
    e.lsb = lsb; e.data = data; e.due = due;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [7:0] data);
    wr_t w;
    w.addr = addr; w.data = data;
    wr_exp.push_back(w);
  endtask

  task automatic lsb_issue(input bit we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
    lsb_we = we; lsb_size = size; lsb_addr = addr; lsb_wdata = wdata; lsb_req = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_a"}, mem_a, 0);
    check({tag, "_mem_dout"}, mem_dout, 0);
    check({tag, "_mem_wr"}, mem_wr, 0);
    check({tag, "_ic_ready"}, ic_ready, 0);
    check({tag, "_lsb_ready"}, lsb_ready, 0);
    check({tag, "_ic_data"}, ic_data, 0);
    check({tag, "_lsb_rdata"}, lsb_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    ic_req = 1'b0; ic_addr = '0; ic_abort = 1'b0;
    lsb_req = 1'b0; lsb_we = 1'b0; lsb_size = '0; lsb_addr = '0; lsb_wdata = '0;
    mem[32'h1000] = 8'h13; mem[32'h1001] = 8'h05; mem[32'h1002] = 8'h00; mem[32'h1003] = 8'h00;
    mem[32'h1004] = 8'h93; mem[32'h1005] = 8'h85; mem[32'h1006] = 8'h05; mem[32'h1007] = 8'h00;
    mem[32'h0200] = 8'h01; mem[32'h0201] = 8'h02; mem[32'h0202] = 8'h03; mem[32'h0203] = 8'h04;
    mem[32'h0300] = 8'h11; mem[32'h0301] = 8'h22; mem[32'h0302] = 8'h33; mem[32'h0303] = 8'h44;

    #3;
    check_all_zero("reset");
    tick(2);
    rst_in = 1'b0;
    tick();

    // Both requesters continuously: LSB first after reset, then alternating.
    c = cyc;
    push_resp(1'b1, 32'h0403_0201, c + 6);
    push_resp(1'b0, 32'h0000_0513, -1);
    push_resp(1'b1, 32'h0000_0403, -1);
    push_resp(1'b0, 32'h0005_8593, -1);
    fork
      begin
        lsb_issue(1'b0, 2'd2, 32'h200, 32'h0);
        wait_ready(1'b1, "t3_lsb0");
        lsb_req = 1'b0;
        tick();
        lsb_issue(1'b0, 2'd1, 32'h202, 32'h0);
        wait_ready(1'b1, "t3_lsb1");
        lsb_req = 1'b0;
      end
      begin
        ic_addr = 32'h1000; ic_req = 1'b1;
        wait_ready(1'b0, "t3_ic0");
        ic_req = 1'b0;
        tick();
        ic_addr = 32'h1004; ic_req = 1'b1;
        wait_ready(1'b0, "t3_ic1");
        ic_req = 1'b0;
      end
    join
    tick();

    // IC fetch: four read byte cycles, ready five edges after accept.
    c = cyc;
    push_resp(1'b0, 32'h0000_0513, c + 6);
    ic_addr = 32'h1000; ic_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_mem_a", mem_a, 32'h1000 + k);
      check("t1_mem_wr", mem_wr, 0);
    end
    wait_ready(1'b0, "t1_ic");
    ic_req = 1'b0;
    tick();

    // Word store: EF BE AD DE at 0x100..0x103, ready four edges after accept.
    c = cyc;
    push_wr(32'h100, 8'hEF); push_wr(32'h101, 8'hBE);
    push_wr(32'h102, 8'hAD); push_wr(32'h103, 8'hDE);
    push_resp(1'b1, 32'h0000_0403, c + 5);
    lsb_issue(1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF);
    wait_ready(1'b1, "t2_store");
    lsb_req = 1'b0;
    tick();

    // Word load paused for two cycles after byte 1 is captured.
    c = cyc;
    push_resp(1'b1, 32'h4433_2211, c + 9);
    lsb_issue(1'b0, 2'd2, 32'h300, 32'h0);
    tick(4);
    rdy_in = 1'b0;
    tick(2);
    rdy_in = 1'b1;
    wait_ready(1'b1, "t4_load");
    lsb_req = 1'b0;
    tick();

    // IO byte store held off by a full uart buffer for three cycles.
    c = cyc;
    push_wr(32'h3_0000, 8'h41);
    push_resp(1'b1, 32'h4433_2211, c + 5);
    io_buffer_full = 1'b1;
    lsb_issue(1'b1, 2'd0, 32'h3_0000, 32'h0000_0041);
    tick(4);
    io_buffer_full = 1'b0;
    wait_ready(1'b1, "t5_io");
    lsb_req = 1'b0;
    tick();

    // IC abort during byte 2 with a pending LSB load.
    c = cyc;
    push_resp(1'b1, 32'h0403_0201, c + 10);
    ic_addr = 32'h1000; ic_req = 1'b1;
    tick();
    lsb_issue(1'b0, 2'd2, 32'h200, 32'h0);
    tick(2);
    ic_abort = 1'b1;
    tick();
    ic_abort = 1'b0; ic_req = 1'b0;
    wait_ready(1'b1, "t6_lsb_after_abort");
    lsb_req = 1'b0;
    check("t6_ic_data_held", ic_data, 32'h0000_0513);
    tick();

    // Asynchronous reset in the middle of a store.
    push_wr(32'h400, 8'h0D);
    lsb_issue(1'b1, 2'd2, 32'h400, 32'hCAFE_F00D);
    tick(2);
    check("t6_mem_wr_mid_store", mem_wr, 1);
    rst_in = 1'b1;
    #1;
    check_all_zero("t6_async_reset");
    lsb_req = 1'b0;
    tick(2);
    rst_in = 1'b0;
    tick(3);

    check("resp_queue_drained", exp_q.size(), 0);
    check("write_queue_drained", wr_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
